// File: rtl/key_sched_ctrl.sv
// -----------------------------------------------------------------------------
// key_sched_ctrl
//
// Iterative AES-256 key-schedule sequencer. One combinational round-key step
// is reused over STEPS cycles to expand a 256-bit cipher key into NUM_RK
// 128-bit round keys. The round keys are held in an internal register file
// and served through a combinational random-access read port.
//
// Ports:
//   clk_i        in   1    sole clock, rising edge
//   reset_i      in   1    asynchronous active-high reset
//   key_v_i      in   1    cipher key valid
//   key_i        in   256  cipher key, bit 0 = MSB ([0:255])
//   key_ready_o  out  1    key_i can be accepted this cycle
//   busy_o       out  1    expansion in progress
//   keys_v_o     out  1    all NUM_RK round keys valid
//   flush_i      in   1    synchronous abort / invalidate (highest priority)
//   rk_addr_i    in   4    round-key index 0..NUM_RK-1
//   rk_o         out  128  rk[rk_addr_i], zero for out-of-range indices
//
// State | meaning
// ------+--------------------------------------------------------------
// IDLE  | no valid key schedule; waiting for a cipher key
// EXPAND| one round-key step per cycle, cnt = 1..STEPS
// DONE  | all round keys valid; a new key restarts the expansion
// -----------------------------------------------------------------------------
module key_sched_ctrl #(
    parameter int NUM_RK = 15,
    parameter int STEPS  = 7
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         key_v_i,
    input  logic [0:255] key_i,
    output logic         key_ready_o,
    output logic         busy_o,
    output logic         keys_v_o,
    input  logic         flush_i,
    input  logic [3:0]   rk_addr_i,
    output logic [0:127] rk_o
);

    localparam logic [3:0] LAST_STEP = 4'(STEPS);
    localparam logic [3:0] LAST_IDX  = 4'(NUM_RK - 1);

    // AES forward S-box, entry n at bits [8n : 8n+7].
    localparam logic [0:2047] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXPAND,
        ST_DONE
    } state_t;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [0:31] sub_word(input logic [0:31] w);
        return {sbox(w[0:7]), sbox(w[8:15]), sbox(w[16:23]), sbox(w[24:31])};
    endfunction

    // Step r produces words 8r..8r+7 and therefore uses Rcon[r].
    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] rc;
        case (r)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    state_t        state_q;
    logic [3:0]    cnt_q;
    logic [0:255]  work_q;
    logic [0:255]  work_d;
    logic          key_ready_q;
    logic          busy_q;
    logic          keys_v_q;
    logic [0:127]  rk_q [NUM_RK];

    logic [3:0]    wr_lo;
    logic [3:0]    wr_hi;

    // One AES-256 key-expansion step over the 8-word working key.
    logic [0:31] w0, w1, w2, w3, w4, w5, w6, w7;
    logic [0:31] n0, n1, n2, n3, n4, n5, n6, n7;
    logic [0:31] t_rot, t_sub;

    always_comb begin
        w0 = work_q[0:31];
        w1 = work_q[32:63];
        w2 = work_q[64:95];
        w3 = work_q[96:127];
        w4 = work_q[128:159];
        w5 = work_q[160:191];
        w6 = work_q[192:223];
        w7 = work_q[224:255];

        t_rot = sub_word({w7[8:31], w7[0:7]}) ^ {rcon(cnt_q), 24'h000000};
        n0 = w0 ^ t_rot;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;

        // Mid-block SubWord without rotation or Rcon (256-bit keys only).
        t_sub = sub_word(n3);
        n4 = w4 ^ t_sub;
        n5 = w5 ^ n4;
        n6 = w6 ^ n5;
        n7 = w7 ^ n6;

        work_d = {n0, n1, n2, n3, n4, n5, n6, n7};
    end

    // Step cnt writes the round-key pair {2*cnt, 2*cnt+1}.
    assign wr_lo = {cnt_q[2:0], 1'b0};
    assign wr_hi = {cnt_q[2:0], 1'b1};

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            work_q      <= '0;
            key_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            keys_v_q    <= 1'b0;
            for (int i = 0; i < NUM_RK; i++) begin
                rk_q[i] <= '0;
            end
        end else if (flush_i) begin
            // Abort wins over everything, including a key offered this cycle.
            // Round-key storage is left as is; keys_v_o already hides it.
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            key_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            keys_v_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (key_v_i && key_ready_q) begin
                        work_q      <= key_i;
                        rk_q[0]     <= key_i[0:127];
                        rk_q[1]     <= key_i[128:255];
                        cnt_q       <= 4'd1;
                        state_q     <= ST_EXPAND;
                        key_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        keys_v_q    <= 1'b0;
                    end
                end
                ST_EXPAND: begin
                    rk_q[wr_lo] <= work_d[0:127];
                    if (cnt_q == LAST_STEP) begin
                        // Last step only yields the final round key; the
                        // upper half of the step result is not needed.
                        state_q     <= ST_DONE;
                        key_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        keys_v_q    <= 1'b1;
                    end else begin
                        rk_q[wr_hi] <= work_d[128:255];
                        work_q      <= work_d;
                        cnt_q       <= cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cnt_q       <= 4'd0;
                    key_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    keys_v_q    <= 1'b0;
                end
            endcase
        end
    end

    assign key_ready_o = key_ready_q;
    assign busy_o      = busy_q;
    assign keys_v_o    = keys_v_q;

    always_comb begin
        rk_o = '0;
        if (rk_addr_i <= LAST_IDX) begin
            rk_o = rk_q[rk_addr_i];
        end
    end

endmodule
